// File: rtl/vga_pkg.sv
// Shared VGA geometry defaults, colour width and the square-motion FSM states.
package vga_pkg;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned COLOR_W      = 2;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CALC_X,
    ST_CALC_Y,
    ST_COMMIT
  } state_t;
endpackage

// File: rtl/bounce_axis.sv
// One-axis step with clamp-and-reflect at 0 and at limit; 11-bit arithmetic so nothing wraps.
module bounce_axis (
  input  logic [9:0]  pos,
  input  logic        dir,
  input  logic [2:0]  speed,
  input  logic [10:0] limit,
  output logic [9:0]  next_pos,
  output logic        next_dir,
  output logic        flipped
);
  logic [10:0] pos_w;
  logic [10:0] speed_w;
  logic [10:0] sum;

  always_comb begin
    pos_w    = {1'b0, pos};
    speed_w  = {8'd0, speed};
    sum      = pos_w + speed_w;
    next_pos = pos;
    next_dir = dir;
    flipped  = 1'b0;
    if (dir && (sum > limit)) begin
      next_pos = limit[9:0];
      next_dir = 1'b0;
      flipped  = 1'b1;
    end else if (!dir && (speed_w > pos_w)) begin
      next_pos = '0;
      next_dir = 1'b1;
      flipped  = 1'b1;
    end else if (dir) begin
      next_pos = sum[9:0];
    end else begin
      next_pos = pos - {7'd0, speed};
    end
  end
endmodule

// File: rtl/square_motion_ctrl.sv
// Bouncing square: once-per-frame position update FSM plus registered pixel colouring.
// Optional COLOR_CYCLE_EN: square colour advances on every frame that bounces.
module square_motion_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned SQ_SIZE  = 100,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               display_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [2:0]         speed,
  input  logic               pause,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               hsync,
  output logic               vsync,
  output logic [9:0]         sq_x,
  output logic [9:0]         sq_y,
  output logic [7:0]         bounce_cnt
);
  localparam logic [10:0] X_LIM  = 11'(H_ACTIVE - SQ_SIZE);
  localparam logic [10:0] Y_LIM  = 11'(V_ACTIVE - SQ_SIZE);
  localparam logic [10:0] SQ_W   = 11'(SQ_SIZE);
  localparam logic [9:0]  V_EVT  = 10'(V_ACTIVE);

  state_t      state, state_nxt;
  logic [9:0]  x, y, nx, ny;
  logic        dx, dy, ndx, ndy, fx, fy;
  logic [2:0]  speed_s;
  logic        pause_s;
  logic        bounced;
  logic        frame_evt;
  logic        move_en;
  logic        in_square;
  logic [COLOR_W-1:0] sq_r, sq_g, sq_b;

  assign frame_evt = (vpos == V_EVT) && (hpos == '0);
  assign move_en   = !pause_s && (speed_s != '0);

  bounce_axis u_axis_x (
    .pos(x), .dir(dx), .speed(speed_s), .limit(X_LIM),
    .next_pos(nx), .next_dir(ndx), .flipped(fx)
  );

  bounce_axis u_axis_y (
    .pos(y), .dir(dy), .speed(speed_s), .limit(Y_LIM),
    .next_pos(ny), .next_dir(ndy), .flipped(fy)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:   if (frame_evt) state_nxt = ST_CALC_X;
      ST_CALC_X: state_nxt = ST_CALC_Y;
      ST_CALC_Y: state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_WAIT;
      default:   state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_WAIT;
      x          <= '0;
      y          <= '0;
      dx         <= 1'b1;
      dy         <= 1'b1;
      speed_s    <= '0;
      pause_s    <= 1'b0;
      bounced    <= 1'b0;
      sq_x       <= '0;
      sq_y       <= '0;
      bounce_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_WAIT: if (frame_evt) begin
          speed_s <= speed;
          pause_s <= pause;
          bounced <= 1'b0;
        end
        ST_CALC_X: if (move_en) begin
          x       <= nx;
          dx      <= ndx;
          bounced <= bounced | fx;
        end
        ST_CALC_Y: if (move_en) begin
          y       <= ny;
          dy      <= ndy;
          bounced <= bounced | fy;
        end
        ST_COMMIT: begin
          sq_x <= x;
          sq_y <= y;
          // A corner hit sets bounced from both axes but still counts once.
          if (bounced) bounce_cnt <= bounce_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef COLOR_CYCLE_EN
  logic [2:0] color_idx;
  logic [2:0] color_pat;

  always_ff @(posedge clk) begin
    if (reset) color_idx <= '0;
    else if ((state == ST_COMMIT) && bounced) color_idx <= color_idx + 3'd1;
  end

  // Inverting the top bit makes index 0 land on pure red.
  assign color_pat = color_idx ^ 3'b100;
  assign sq_r = {COLOR_W{color_pat[2]}};
  assign sq_g = {COLOR_W{color_pat[1]}};
  assign sq_b = {COLOR_W{color_pat[0]}};
`else
  assign sq_r = '1;
  assign sq_g = '0;
  assign sq_b = '0;
`endif

  assign in_square = display_on
                  && (hpos >= sq_x) && ({1'b0, hpos} < ({1'b0, sq_x} + SQ_W))
                  && (vpos >= sq_y) && ({1'b0, vpos} < ({1'b0, sq_y} + SQ_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      R     <= '0;
      G     <= '0;
      B     <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      R     <= in_square ? sq_r : '0;
      G     <= in_square ? sq_g : '0;
      B     <= in_square ? sq_b : '0;
      hsync <= hsync_in;
      vsync <= vsync_in;
    end
  end
endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed bench for square_motion_ctrl: main instance plus a 640x640 instance for corner hits.
module tb_square_motion_ctrl;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos, vpos2;
  logic       display_on, hsync_in, vsync_in;
  logic [2:0] speed, speed2;
  logic       pause;

  logic [1:0] R, G, B, c_R, c_G, c_B;
  logic       hsync, vsync, c_hsync, c_vsync;
  logic [9:0] sq_x, sq_y, c_sq_x, c_sq_y;
  logic [7:0] bounce_cnt, c_bounce_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  square_motion_ctrl #(.SQ_SIZE(100), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .speed(speed), .pause(pause),
    .R(R), .G(G), .B(B), .hsync(hsync), .vsync(vsync),
    .sq_x(sq_x), .sq_y(sq_y), .bounce_cnt(bounce_cnt)
  );

  square_motion_ctrl #(.SQ_SIZE(100), .H_ACTIVE(640), .V_ACTIVE(640)) u_corner (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos2), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .speed(speed2), .pause(pause),
    .R(c_R), .G(c_G), .B(c_B), .hsync(c_hsync), .vsync(c_vsync),
    .sq_x(c_sq_x), .sq_y(c_sq_y), .bounce_cnt(c_bounce_cnt)
  );

`ifdef COLOR_CYCLE_EN
  logic [1:0] t_R, t_G, t_B;
  logic       t_hsync, t_vsync;
  logic [9:0] t_sq_x, t_sq_y;
  logic [7:0] t_bounce_cnt;

  // Limit 4 on both axes: every frame at speed 7 bounces.
  square_motion_ctrl #(.SQ_SIZE(636), .H_ACTIVE(640), .V_ACTIVE(640)) u_tiny (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos2), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .speed(speed2), .pause(pause),
    .R(t_R), .G(t_G), .B(t_B), .hsync(t_hsync), .vsync(t_vsync),
    .sq_x(t_sq_x), .sq_y(t_sq_y), .bounce_cnt(t_bounce_cnt)
  );
  localparam logic [1:0] EXP_G_CNT2 = 2'b11;
`else
  localparam logic [1:0] EXP_G_CNT2 = 2'b00;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    display_on = 1'b0;
    hpos  = 10'd0;
    vpos  = 10'd480;
    vpos2 = 10'd640;
    tick();
    vpos  = 10'd0;
    vpos2 = 10'd0;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; hpos = '0; vpos = '0; vpos2 = '0; display_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; speed = 3'd0; speed2 = 3'd0; pause = 1'b0;
    repeat (3) tick();

    check("rst_sq_x", 32'(sq_x), 0);
    check("rst_sq_y", 32'(sq_y), 0);
    check("rst_bounce", 32'(bounce_cnt), 0);
    check("rst_R", 32'(R), 0);
    check("rst_hsync", 32'(hsync), 0);
    check("rst_vsync", 32'(vsync), 0);
    check("rst_state", 32'(dut.state), 32'(ST_WAIT));

    reset = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    speed = 3'd2; speed2 = 3'd2;
    frame();
    check("first_sq_x", 32'(sq_x), 2);
    check("first_sq_y", 32'(sq_y), 2);
    check("first_bounce", 32'(bounce_cnt), 0);

    reset = 1'b1; tick(); reset = 1'b0;
    speed = 3'd7; speed2 = 3'd7;
    repeat (76) frame();
    // y clamps to 380 on frame 55, then runs 21 frames downward.
    check("run76_sq_x", 32'(sq_x), 532);
    check("run76_sq_y", 32'(sq_y), 233);
    check("run76_bounce", 32'(bounce_cnt), 1);
    check("run76_c_sq_x", 32'(c_sq_x), 532);

    speed = 3'd6; speed2 = 3'd6;
    frame();
    check("f77_sq_x", 32'(sq_x), 538);
    check("f77_sq_y", 32'(sq_y), 227);
    check("f77_c_sq_y", 32'(c_sq_y), 538);

    speed = 3'd5; speed2 = 3'd4;
    frame();
    check("xbounce_sq_x", 32'(sq_x), 540);
    check("xbounce_sq_y", 32'(sq_y), 222);
    check("xbounce_cnt", 32'(bounce_cnt), 2);
    check("corner_sq_x", 32'(c_sq_x), 540);
    check("corner_sq_y", 32'(c_sq_y), 540);
    check("corner_cnt", 32'(c_bounce_cnt), 1);

    speed = 3'd5; speed2 = 3'd0;
    frame();
    check("xback_sq_x", 32'(sq_x), 535);
    check("xback_sq_y", 32'(sq_y), 217);
    check("speed0_c_sq_x", 32'(c_sq_x), 540);
    check("speed0_c_cnt", 32'(c_bounce_cnt), 1);

    pause = 1'b1; speed = 3'd7;
    repeat (3) frame();
    check("pause_sq_x", 32'(sq_x), 535);
    check("pause_sq_y", 32'(sq_y), 217);
    check("pause_cnt", 32'(bounce_cnt), 2);

    display_on = 1'b1; hpos = 10'd535; vpos = 10'd217; hsync_in = 1'b1;
    tick();
    check("pix_corner_R", 32'(R), 3);
    check("pix_corner_G", 32'(G), 32'(EXP_G_CNT2));
    check("pix_corner_B", 32'(B), 0);
    check("pix_hsync", 32'(hsync), 1);
    hpos = 10'd634;
    tick();
    check("pix_lastcol_R", 32'(R), 3);
    hpos = 10'd635;
    tick();
    check("pix_right_edge_R", 32'(R), 0);
    hpos = 10'd535; vpos = 10'd216;
    tick();
    check("pix_above_R", 32'(R), 0);
    vpos = 10'd217; display_on = 1'b0;
    tick();
    check("pix_blank_R", 32'(R), 0);

    hsync_in = 1'b0;
    tick();
    hsync_in = 1'b1;
    #1;
    check("hsync_not_yet", 32'(hsync), 0);
    tick();
    check("hsync_delayed", 32'(hsync), 1);

    pause = 1'b0; speed = 3'd1;
    hpos = 10'd0; vpos = 10'd480;
    tick();
    vpos = 10'd0;
    tick();
    check("abort_in_calc_y", 32'(dut.state), 32'(ST_CALC_Y));
    reset = 1'b1;
    tick();
    check("abort_state", 32'(dut.state), 32'(ST_WAIT));
    check("abort_sq_x", 32'(sq_x), 0);
    check("abort_sq_y", 32'(sq_y), 0);
    reset = 1'b0;
    repeat (3) tick();
    check("abort_no_commit_x", 32'(sq_x), 0);
    check("abort_no_commit_cnt", 32'(bounce_cnt), 0);

`ifdef COLOR_CYCLE_EN
    speed2 = 3'd7;
    frame();
    check("tiny_cnt1", 32'(t_bounce_cnt), 1);
    repeat (7) frame();
    check("tiny_cnt8", 32'(t_bounce_cnt), 8);
    display_on = 1'b1; hpos = 10'd0; vpos2 = 10'd0;
    tick();
    check("tiny_red_R", 32'(t_R), 3);
    check("tiny_red_G", 32'(t_G), 0);
    check("tiny_red_B", 32'(t_B), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
